// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared HILO op codes and multiply/divide FSM encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hilo_muldiv_unit_pkg;

  // HILO op codes as driven by decode alongside HILOwe
  localparam logic [2:0] HILO_MULT  = 3'b000;
  localparam logic [2:0] HILO_MULTU = 3'b001;
  localparam logic [2:0] HILO_DIV   = 3'b010;
  localparam logic [2:0] HILO_DIVU  = 3'b011;
  localparam logic [2:0] HILO_MTHI  = 3'b100;
  localparam logic [2:0] HILO_MTLO  = 3'b101;
  localparam logic [2:0] HILO_NONE  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DFIX = 2'd3
  } hilo_state_e;

  // MULT and DIV treat operands as two's complement; everything else is unsigned
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == HILO_MULT) || (op == HILO_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Execute-stage <-> HILO unit bundle: op request in, busy/done/HI/LO out.
// Latency: n/a (wiring only).
// Backpressure: busy tells the requester to hold its instruction.
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_unit_div_iter.sv
// Restoring divider core on magnitudes, one quotient bit per step, MSB first.
// Latency: WIDTH asserted step cycles after start; valid rises with the last step.
// Backpressure: none; steps advance only while the parent holds step high.
module hilo_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);

  localparam int SW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] d_q;
  logic [SW-1:0]    steps_q;
  logic             valid_q;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             borrow;

  // Trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    rem_sh = {r_q, q_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, d_q};
    borrow = diff[WIDTH];
  end

  // Shift in one quotient bit per step; restore the remainder on borrow
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      steps_q <= '0;
      valid_q <= 1'b0;
    end else if (start) begin
      q_q     <= dividend;
      r_q     <= '0;
      d_q     <= divisor;
      steps_q <= '0;
      valid_q <= 1'b0;
    end else if (step && !valid_q) begin
      q_q     <= {q_q[WIDTH-2:0], ~borrow};
      r_q     <= borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      steps_q <= steps_q + SW'(1);
      valid_q <= (steps_q == SW'(WIDTH - 1));
    end
  end

  assign quotient  = q_q;
  assign remainder = r_q;
  assign valid     = valid_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner: MTHI/MTLO in one edge, multi-cycle MULT(U), iterative DIV(U).
// Latency: MULT(U) busy MULT_CYCLES cycles, DIV(U) busy WIDTH+1 cycles, done pulses after.
// Backpressure: busy high while an op is in flight; new starts are ignored until idle.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5
) (
  input logic              clk,
  input logic              reset,
  hilo_muldiv_unit_if.slave bus
);

  localparam int CNT_MAX = (MULT_CYCLES > WIDTH) ? (MULT_CYCLES - 1) : (WIDTH - 1);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(WIDTH - 1);

  hilo_state_e        state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [WIDTH-1:0]   hi_q, hi_n;
  logic [WIDTH-1:0]   lo_q, lo_n;
  logic               done_q, done_n;
  logic [2*WIDTH-1:0] prod_q, prod_n;
  logic               q_neg, q_neg_n;
  logic               r_neg, r_neg_n;
  logic               bzero, bzero_n;
  logic [WIDTH-1:0]   div_a, div_a_n;

  logic               sgn;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] product;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic               div_start;
  logic               div_step;
  logic [WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]   div_r;
  logic               div_valid;

  // Operand conditioning: extended product and WIDTH-bit magnitudes
  always_comb begin
    sgn     = is_signed_op(bus.op);
    a_ext   = sgn ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
    b_ext   = sgn ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
    product = a_ext * b_ext;
    a_neg   = sgn & bus.a[WIDTH-1];
    b_neg   = sgn & bus.b[WIDTH-1];
    a_mag   = a_neg ? -bus.a : bus.a;
    b_mag   = b_neg ? -bus.b : bus.b;
  end

  hilo_div_iter #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .step      (div_step),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_q),
    .remainder (div_r),
    .valid     (div_valid)
  );

  // Next state, HI/LO write-back and operand latching
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hi_n      = hi_q;
    lo_n      = lo_q;
    done_n    = 1'b0;
    prod_n    = prod_q;
    q_neg_n   = q_neg;
    r_neg_n   = r_neg;
    bzero_n   = bzero;
    div_a_n   = div_a;
    div_start = 1'b0;
    div_step  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          case (bus.op)
            HILO_MTHI: hi_n = bus.a;
            HILO_MTLO: lo_n = bus.a;
            HILO_MULT, HILO_MULTU: begin
              prod_n  = product;
              cnt_n   = MUL_LOAD;
              state_n = ST_MUL;
            end
            HILO_DIV, HILO_DIVU: begin
              q_neg_n   = a_neg ^ b_neg;
              r_neg_n   = a_neg;
              bzero_n   = (bus.b == '0);
              div_a_n   = bus.a;
              div_start = 1'b1;
              cnt_n     = DIV_LOAD;
              state_n   = ST_DIV;
            end
            default: ;
          endcase
        end
      end

      ST_MUL: begin
        if (bus.flush) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else if (cnt == '0) begin
          {hi_n, lo_n} = prod_q;
          done_n       = 1'b1;
          state_n      = ST_IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end

      ST_DIV: begin
        if (bus.flush) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          div_step = 1'b1;
          if (cnt == '0) begin
            state_n = ST_DFIX;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
      end

      ST_DFIX: begin
        state_n = ST_IDLE;
        if (!bus.flush && div_valid) begin
          done_n = 1'b1;
          if (bzero) begin
            hi_n = div_a;
            lo_n = '1;
          end else begin
            lo_n = q_neg ? -div_q : div_q;
            hi_n = r_neg ? -div_r : div_r;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // State, counter, HI/LO and latched operands
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      prod_q <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      bzero  <= 1'b0;
      div_a  <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      hi_q   <= hi_n;
      lo_q   <= lo_n;
      done_q <= done_n;
      prod_q <= prod_n;
      q_neg  <= q_neg_n;
      r_neg  <= r_neg_n;
      bzero  <= bzero_n;
      div_a  <= div_a_n;
    end
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed and randomized checks of hilo_muldiv_unit against an arithmetic model.
// Latency: checks exact busy length per op and the done pulse timing.
// Backpressure: exercises start-while-busy, flush and reset interactions.
module tb_hilo_muldiv_unit;
  import hilo_muldiv_unit_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hilo_muldiv_unit_if #(.WIDTH(W)) bus();

  hilo_muldiv_unit #(
    .WIDTH       (W),
    .MULT_CYCLES (MC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Architectural result of one op; lat is the expected busy length
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat);
    longint      ps;
    logic [63:0] pu;
    int          sx, sy;
    lat = 0;
    sx  = x;
    sy  = y;
    case (o)
      HILO_MTHI: m_hi = x;
      HILO_MTLO: m_lo = x;
      HILO_MULT: begin
        ps = longint'(sx) * longint'(sy);
        {m_hi, m_lo} = ps;
        lat = MC;
      end
      HILO_MULTU: begin
        pu = {32'b0, x} * {32'b0, y};
        {m_hi, m_lo} = pu;
        lat = MC;
      end
      HILO_DIV: begin
        lat = W + 1;
        if (y == 0) begin
          m_hi = x; m_lo = '1;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000; m_hi = 0;
        end else begin
          m_lo = sx / sy;
          m_hi = sx % sy;
        end
      end
      HILO_DIVU: begin
        lat = W + 1;
        if (y == 0) begin
          m_hi = x; m_lo = '1;
        end else begin
          m_lo = x / y;
          m_hi = x % y;
        end
      end
      default: ;
    endcase
  endtask

  // Present one request for a single edge; returns at the first negedge after acceptance
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(negedge clk);
    bus.start = 1'b0; bus.op = HILO_NONE;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input string tag);
    int lat, cyc;
    model(o, x, y, lat);
    issue(o, x, y);
    wait_idle(cyc);
    check({tag, ".busy_cycles"}, 64'(cyc), 64'(lat));
    check({tag, ".done"}, 64'(bus.done), 64'(lat != 0));
    @(negedge clk);
    check({tag, ".done_drop"}, 64'(bus.done), 64'(0));
    check({tag, ".hi"}, 64'(bus.hi), 64'(m_hi));
    check({tag, ".lo"}, 64'(bus.lo), 64'(m_lo));
  endtask

  function automatic logic [31:0] pick(input int zero_bias);
    int r;
    r = $urandom_range(0, 9);
    if (r < zero_bias) return 32'h0;
    if (r == 3) return 32'h8000_0000;
    if (r == 4) return 32'hFFFF_FFFF;
    if (r == 5) return 32'($urandom_range(1, 20));
    return $urandom;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          cyc, lat;
    logic [31:0] lo_before, hi_before;
    logic [2:0]  o;

    reset = 1'b1;
    bus.start = 1'b0; bus.op = HILO_NONE; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    check("reset.hi",   64'(bus.hi),   64'(0));
    check("reset.lo",   64'(bus.lo),   64'(0));
    check("reset.busy", 64'(bus.busy), 64'(0));
    check("reset.done", 64'(bus.done), 64'(0));
    reset = 1'b0;

    // Directed plan cases with literal expectations
    do_op(HILO_MULT, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5");
    check("mult_lit.hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_lit.lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFF1);
    do_op(HILO_MULTU, 32'hFFFF_FFFF, 32'd2, "multu");
    check("multu_lit.hi", 64'(bus.hi), 64'h1);
    check("multu_lit.lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFE);
    do_op(HILO_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
    check("div_lit.lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
    check("div_lit.hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    do_op(HILO_DIVU, 32'd7, 32'd0, "divu_by0");
    check("divu0_lit.hi", 64'(bus.hi), 64'h7);
    check("divu0_lit.lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFF);
    do_op(HILO_DIV, 32'hFFFF_FFF0, 32'd0, "div_by0");
    do_op(HILO_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("ovf_lit.lo", 64'(bus.lo), 64'h0000_0000_8000_0000);
    do_op(HILO_DIV, 32'd7, 32'hFFFF_FFFE, "div_7byneg2");
    do_op(HILO_NONE, 32'h5555_5555, 32'd1, "op_none");
    do_op(3'b110, 32'h6666_6666, 32'd1, "op_undef");

    // Flush at the tenth busy cycle of a divide
    do_op(HILO_MTHI, 32'h0000_1234, 32'd0, "mthi");
    lo_before = m_lo;
    issue(HILO_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush.busy", 64'(bus.busy), 64'(0));
    check("flush.done", 64'(bus.done), 64'(0));
    repeat (3) @(negedge clk);
    check("flush.done_late", 64'(bus.done), 64'(0));
    check("flush.hi", 64'(bus.hi), 64'h1234);
    check("flush.lo", 64'(bus.lo), 64'(lo_before));

    // Flush on the write cycle of a multiply suppresses the write
    hi_before = m_hi; lo_before = m_lo;
    issue(HILO_MULT, 32'd11, 32'd13);
    repeat (MC - 1) @(negedge clk);
    check("wflush.busy_before", 64'(bus.busy), 64'(1));
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("wflush.busy", 64'(bus.busy), 64'(0));
    check("wflush.done", 64'(bus.done), 64'(0));
    check("wflush.hi", 64'(bus.hi), 64'(hi_before));
    check("wflush.lo", 64'(bus.lo), 64'(lo_before));

    // MTLO presented while a multiply is busy is ignored
    model(HILO_MULT, 32'h0001_0001, 32'h0000_0100, lat);
    issue(HILO_MULT, 32'h0001_0001, 32'h0000_0100);
    bus.start = 1'b1; bus.op = HILO_MTLO; bus.a = 32'hAA;
    @(negedge clk);
    bus.start = 1'b0; bus.op = HILO_NONE;
    wait_idle(cyc);
    check("mtlo_busy.cycles", 64'(cyc + 1), 64'(lat));
    @(negedge clk);
    check("mtlo_busy.lo", 64'(bus.lo), 64'(m_lo));
    check("mtlo_busy.hi", 64'(bus.hi), 64'(m_hi));

    // Start with flush in idle is dropped
    @(negedge clk);
    bus.start = 1'b1; bus.op = HILO_MTHI; bus.a = 32'hDEAD; bus.flush = 1'b1;
    @(negedge clk);
    bus.op = HILO_DIVU;
    @(negedge clk);
    bus.start = 1'b0; bus.op = HILO_NONE; bus.flush = 1'b0;
    check("idle_flush.hi", 64'(bus.hi), 64'(m_hi));
    check("idle_flush.busy", 64'(bus.busy), 64'(0));

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: o = HILO_MULT;
        1: o = HILO_MULTU;
        2: o = HILO_DIV;
        3: o = HILO_DIVU;
        4: o = HILO_MTHI;
        default: o = HILO_MTLO;
      endcase
      do_op(o, pick(1), pick(2), $sformatf("rand%0d_op%0d", i, o));
    end

    // Reset mid-divide
    issue(HILO_DIV, 32'h1234_5678, 32'd9);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid.hi",   64'(bus.hi),   64'(0));
    check("rst_mid.lo",   64'(bus.lo),   64'(0));
    check("rst_mid.busy", 64'(bus.busy), 64'(0));
    check("rst_mid.done", 64'(bus.done), 64'(0));
    m_hi = '0; m_lo = '0;
    do_op(HILO_DIVU, 32'd100, 32'd7, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Multi-cycle HI/LO multiply/divide unit for the execute stage. It replaces the single-cycle HILO write path. It accepts the existing 3-bit HILO op code (MULT, MULTU, DIV, DIVU, MTHI, MTLO; 3'b111 means none) together with the rs/rt operands. It runs multiplies with a fixed programmable latency and divides iteratively, one bit per cycle. It asserts busy so the hazard unit can stall, and it owns the architectural HI/LO registers.

Parameters:
WIDTH, 32, operand and HI/LO register width; must be a power of two and at least 8.
MULT_CYCLES, 5, busy cycles for MULT/MULTU; must be at least 1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  HILO write-enable from decode (HILOwe); qualifies op
op  in  3  HILO op code; shared package constants
a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
b  in  WIDTH  rt operand (divisor / multiplier)
flush  in  1  exception/eret cancel of the in-flight operation
busy  out  1  operation in flight; stall any HILO consumer
done  out  1  one-cycle pulse when a MULT/DIV result is written
hi  out  WIDTH  architectural HI register
lo  out  WIDTH  architectural LO register

Behaviour:
- One clock (clk); reset is synchronous and active-high. Reset in any state gives: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation discards the in-flight operation.
- FSM states: IDLE, MUL, DIV, DFIX. busy=1 exactly when state!=IDLE. done is registered.
- IDLE, start=1, flush=0:
  - MTHI: hi<=a at the edge. MTLO: lo<=a. Stay in IDLE; busy and done are not asserted.
  - MULT/MULTU: latch the full 2*WIDTH product at that edge (signed or unsigned), cnt<=MULT_CYCLES-1, go to MUL.
  - DIV/DIVU: latch |a|, |b| (raw values for DIVU) and the sign of the quotient and the sign of the remainder. Clear the partial remainder, cnt<=WIDTH-1, go to DIV.
  - op=3'b111 or any undefined code: no effect.
- MUL: cnt decrements each cycle. On the cycle with cnt==0: {hi,lo}<=product, done<=1, go to IDLE. busy is high for exactly MULT_CYCLES cycles.
- DIV: restoring divide, one quotient bit per cycle, MSB first. On the cycle with cnt==0, go to DFIX.
- DFIX: apply signs. Quotient is negated when the operand signs differ. Remainder takes the dividend's sign. Then lo<=quotient, hi<=remainder, done<=1, go to IDLE. busy is high for exactly WIDTH+1 cycles.
- Divide by zero (b==0) is handled identically for DIV and DIVU: hi<=a, lo<={WIDTH{1'b1}}. The divide still takes the full latency.
- Signed overflow (a=MIN, b=-1): lo<=MIN, hi<=0. This falls out of the datapath naturally.
- start while busy is ignored, including MTHI/MTLO; the upstream stage must hold the instruction while busy.
- flush while busy: go to IDLE at the next edge. hi/lo keep their pre-operation values and done stays 0.
- flush together with start in IDLE: flush wins and the start is dropped.
- flush in the same cycle a result would be written: the write is suppressed.
- hi/lo are never partially updated.
- Arithmetic: products are computed at 2*WIDTH bits with sign extension for MULT. All absolute-value and negation logic is WIDTH bits wrap-around.

Decomposition:
- Shared package (public header): HILO op codes MULT, MULTU, DIV, DIVU, MTHI, MTLO, and NONE=3'b111; the FSM state encodings.
- One sub-module, hilo_div_iter: the iterative restoring divider core.
  - Inputs: start, dividend and divisor magnitudes.
  - Outputs: quotient and remainder magnitudes, plus a valid flag.
  - Sign fix and write-back stay in the parent.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> busy for 5 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy for 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7, b=0 -> hi=0x00000007, lo=0xFFFFFFFF.
- MTHI 0x1234 then DIV with flush asserted at busy cycle 10:
  - busy drops at the next edge.
  - done is never asserted.
  - hi stays 0x1234 and lo is unchanged.
- MTLO 0xAA issued while MUL is busy -> ignored; lo ends with the product. Reset asserted mid-DIV -> hi=lo=0 and busy=0 on the next edge.
